// File: rtl/linebuf_addr_ctrl_if.sv
// Stream and SRAM-port bundle between the line-buffer controller and its neighbours.
interface linebuf_addr_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] waddr;
  logic              wen_in;
  logic [ADDR_W-1:0] raddr;
  logic              ren_in;
  logic [DATA_W-1:0] rdata;

  modport master (
    output in_data, in_valid, rdata,
    input  in_ready, out_data, out_valid, wdata, waddr, wen_in, raddr, ren_in
  );

  modport slave (
    input  in_data, in_valid, rdata,
    output in_ready, out_data, out_valid, wdata, waddr, wen_in, raddr, ren_in
  );
endinterface

// File: rtl/linebuf_addr_ctrl.sv
// Circular-buffer address controller: writes the pixel stream into a dual-port SRAM and
// reads it back DELAY pixels later, draining the buffered words at the end of each frame.
module linebuf_addr_ctrl #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 8,
  parameter int DELAY        = 4,
  parameter int FRAME_PIXELS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  linebuf_addr_ctrl_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DELAY + 1);
  localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STEADY = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             out_valid_q;

  logic in_ready_s;
  logic acc_s;
  logic ren_s;
  logic last_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Next-state and handshake decode
  always_comb begin
    in_ready_s = (state_q != ST_DRAIN);
    acc_s      = bus.in_valid & in_ready_s;
    last_s     = acc_s && (pix_q == PIX_W'(FRAME_PIXELS - 1));

    case (state_q)
      ST_STEADY: ren_s = acc_s;
      ST_DRAIN:  ren_s = (occ_q != {OCC_W{1'b0}});
      default:   ren_s = 1'b0;
    endcase

    if (acc_s) begin
      wptr_d = ptr_inc(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end

    if (ren_s) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end

    if (acc_s && !ren_s) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!acc_s && ren_s) begin
      occ_d = occ_q - OCC_W'(1);
    end else begin
      occ_d = occ_q;
    end

    if (last_s) begin
      pix_d = {PIX_W{1'b0}};
    end else if (acc_s) begin
      pix_d = pix_q + PIX_W'(1);
    end else begin
      pix_d = pix_q;
    end

    // Frame end wins over the fill/steady decision made on the same pixel.
    state_d = state_q;
    if (last_s) begin
      state_d = ST_DRAIN;
    end else begin
      case (state_q)
        ST_FILL:   state_d = (occ_d == OCC_W'(DELAY)) ? ST_STEADY : ST_FILL;
        ST_STEADY: state_d = ST_STEADY;
        ST_DRAIN:  state_d = (occ_d == {OCC_W{1'b0}}) ? ST_FILL : ST_DRAIN;
        default:   state_d = ST_FILL;
      endcase
    end
  end

  // State, pointer and counter registers; flush clears like reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      wptr_q      <= {PTR_W{1'b0}};
      rptr_q      <= {PTR_W{1'b0}};
      occ_q       <= {OCC_W{1'b0}};
      pix_q       <= {PIX_W{1'b0}};
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= ST_FILL;
      wptr_q      <= {PTR_W{1'b0}};
      rptr_q      <= {PTR_W{1'b0}};
      occ_q       <= {OCC_W{1'b0}};
      pix_q       <= {PIX_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      occ_q       <= occ_d;
      pix_q       <= pix_d;
      out_valid_q <= ren_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.wen_in    = acc_s;
  assign bus.waddr     = ADDR_W'(wptr_q);
  assign bus.wdata     = bus.in_data;
  assign bus.ren_in    = ren_s;
  assign bus.raddr     = ADDR_W'(rptr_q);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = bus.rdata;
endmodule

// File: tb/tb_linebuf_addr_ctrl.sv
// Vector table plus read-data scoreboard for linebuf_addr_ctrl with a registered-read SRAM model.
module tb_linebuf_addr_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  linebuf_addr_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus();

  linebuf_addr_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(8), .DELAY(4), .FRAME_PIXELS(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush),
    .bus(bus)
  );

  logic [15:0] mem [0:7];
  always @(posedge clk) begin
    if (bus.wen_in) mem[bus.waddr[2:0]] <= bus.wdata;
    if (bus.ren_in) bus.rdata <= mem[bus.raddr[2:0]];
  end

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        fl;
    logic        rdy;
    logic        wen;
    logic [15:0] wa;
    logic        ren;
    logic [15:0] ra;
    logic [15:0] rd;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] sb[$];
  logic        exp_ov = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic vec_t mk(logic v, logic [15:0] d, logic fl, logic rdy, logic wen,
                              logic [15:0] wa, logic ren, logic [15:0] ra, logic [15:0] rd);
    vec_t t;
    t.v = v; t.d = d; t.fl = fl; t.rdy = rdy; t.wen = wen;
    t.wa = wa; t.ren = ren; t.ra = ra; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out();
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_data: out_valid with no expected word (t=%0t)", $time);
      end else begin
        chk("out_data", bus.out_data, sb.pop_front());
      end
    end
  endtask

  task automatic step(input vec_t t);
    @(posedge clk);
    #1;
    bus.in_valid = t.v;
    bus.in_data  = t.d;
    flush        = t.fl;
    @(negedge clk);
    chk("in_ready", bus.in_ready, t.rdy);
    chk("wen_in", bus.wen_in, t.wen);
    chk("waddr", bus.waddr, t.wa);
    chk("ren_in", bus.ren_in, t.ren);
    chk("raddr", bus.raddr, t.ra);
    chk("out_valid", bus.out_valid, exp_ov);
    chk_out();
    if (t.ren) sb.push_back(t.rd);
    exp_ov = t.ren;
  endtask

  task automatic chk_idle_reset();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_wen_in", bus.wen_in, 0);
    chk("rst_ren_in", bus.ren_in, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_raddr", bus.raddr, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 16'd0;

    // First frame: fill, steady with a gap and wrap, then drain.
    tbl.push_back(mk(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(1'b1, 16'(i), 1'b0, 1'b1, 1'b1, 16'(i - 1), 1'b0, 16'd0, 16'd0));
    tbl.push_back(mk(1'b1, 16'd5, 1'b0, 1'b1, 1'b1, 16'd4, 1'b1, 16'd0, 16'd1));
    tbl.push_back(mk(1'b1, 16'd6, 1'b0, 1'b1, 1'b1, 16'd5, 1'b1, 16'd1, 16'd2));
    tbl.push_back(mk(1'b1, 16'd7, 1'b0, 1'b1, 1'b1, 16'd6, 1'b1, 16'd2, 16'd3));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd7, 1'b0, 16'd3, 16'd0));
    tbl.push_back(mk(1'b1, 16'd8, 1'b0, 1'b1, 1'b1, 16'd7, 1'b1, 16'd3, 16'd4));
    tbl.push_back(mk(1'b1, 16'd9, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 16'd4, 16'd5));
    tbl.push_back(mk(1'b1, 16'd10, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 16'd5, 16'd6));
    tbl.push_back(mk(1'b1, 16'h99, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 16'd6, 16'd7));
    tbl.push_back(mk(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 16'd7, 16'd8));
    tbl.push_back(mk(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 16'd0, 16'd9));
    tbl.push_back(mk(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 16'd1, 16'd10));
    tbl.push_back(mk(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 16'd2, 16'd0));
    tbl.push_back(mk(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 16'd2, 16'd0));

    #12;
    chk_idle_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle_reset();

    foreach (tbl[i]) step(tbl[i]);

    // Second frame: reach STEADY, then flush and confirm the buffer refills from zero.
    for (int i = 0; i < 4; i++)
      step(mk(1'b1, 16'(11 + i), 1'b0, 1'b1, 1'b1, 16'(2 + i), 1'b0, 16'd2, 16'd0));
    step(mk(1'b1, 16'd15, 1'b0, 1'b1, 1'b1, 16'd6, 1'b1, 16'd2, 16'd11));
    step(mk(1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd7, 1'b0, 16'd3, 16'd0));
    step(mk(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0));
    for (int i = 0; i < 4; i++)
      step(mk(1'b1, 16'(21 + i), 1'b0, 1'b1, 1'b1, 16'(i), 1'b0, 16'd0, 16'd0));
    step(mk(1'b1, 16'd25, 1'b0, 1'b1, 1'b1, 16'd4, 1'b1, 16'd0, 16'd21));
    for (int i = 0; i < 5; i++)
      step(mk(1'b1, 16'(26 + i), 1'b0, 1'b1, 1'b1, 16'((5 + i) % 8), 1'b1, 16'(1 + i), 16'(22 + i)));
    step(mk(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 16'd6, 16'd27));

    // Asynchronous reset in the middle of the drain.
    @(posedge clk);
    #1;
    chk("drain_ren_in", bus.ren_in, 1);
    chk("drain_raddr", bus.raddr, 7);
    chk("drain_out_valid", bus.out_valid, 1);
    chk_out();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_ren_in", bus.ren_in, 0);
    chk("async_in_ready", bus.in_ready, 1);
    chk("async_raddr", bus.raddr, 0);
    sb.delete();
    exp_ov = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step(mk(1'b1, 16'd31, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 16'd0, 16'd0));
    step(mk(1'b1, 16'd32, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 16'd0, 16'd0));
    step(mk(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 16'd0, 16'd0));

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
